dsp_post_adder_acc: RTL and testbench
=====================================

// Module: dsp_post_adder_acc
// PURPOSE
//  Post-adder/accumulator stage of the DSP48A1 slice model. Consumes the 36-bit multiplier product,
//  the {D,A,B} concatenation, C and cascade PCIN from the upstream input/multiply stages.
//  Selects X/Z operands via OPMODE, adds or subtracts them with carry-in, and registers the result in P.
//  Drives P, PCOUT and CARRYOUT to the slice outputs and to the next slice's PCIN.
// PARAMETERS
//  PREG        1          1: P and CARRYOUT registered; 0: combinational outputs
//  OPMODEREG   1          1: OPMODE registered (enable ce_opmode); 0: used directly
//  CARRYINREG  1          1: selected carry-in registered (enable ce_carryin); 0: direct
//  CARRYINSEL  "OPMODE5"  carry-in source: "OPMODE5" = opmode[5]; "CARRYIN" = carryin port
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst_n        in   1   asynchronous active-low reset; clears every internal register
//  ce_opmode    in   1   OPMODE register enable
//  ce_carryin   in   1   carry-in register enable
//  ce_p         in   1   P/CARRYOUT register enable
//  opmode       in   8   [1:0] X sel, [3:2] Z sel, [5] carry-in, [7] 1 = subtract; [4],[6] ignored
//  carryin      in   1   external carry-in
//  m            in   36  multiplier product, unsigned, zero-extended to 48
//  dab          in   48  {d[11:0], a[17:0], b[17:0]}
//  c            in   48  C operand
//  pcin         in   48  cascade input from the previous slice
//  p            out  48  result
//  pcout        out  48  identical copy of p for cascade
//  carryout     out  1   bit 48 of the 49-bit post-adder result
//  carryoutf    out  1   fabric copy of carryout
// BEHAVIOUR
//  Reset: rst_n low immediately forces p, pcout, carryout, carryoutf to 0. The opmode and carry-in
//   registers also clear. Reset mid-accumulation discards the sum. Recovery is synchronous to clk.
//  X mux: 0 -> 0; 1 -> {12'b0,m}; 2 -> P register; 3 -> dab.
//  Z mux: 0 -> 0; 1 -> pcin; 2 -> P register; 3 -> c.
//  Arithmetic is 49-bit unsigned.
//   opmode[7]=0: r = Z + X + cin.
//   opmode[7]=1: r = Z - (X + cin).
//   p = r[47:0]; carryout = r[48]. On subtract, r[48]=1 indicates a borrow.
//  Latency, PREG=1: the result of the operands present at edge N appears on p after edge N.
//   ce_p=0 holds p and carryout.
//  Latency, PREG=0: p follows the operands combinationally.
//   An X or Z select of 2 then yields 0; no combinational loop is permitted.
//   Simulation asserts a warning when this occurs.
//  OPMODEREG=1: opmode captured when ce_opmode=1; the captured value takes effect from the next cycle.
//  CARRYINREG=1: the selected cin is captured when ce_carryin=1.
//  Accumulate (X=1, Z=2) wraps modulo 2^48. A wrap sets carryout for that cycle only.
//  Simultaneous events: ce_p=1 with rst_n low -> reset wins. All enables low -> full hold.
// CONFIGURATION
//  DSP_POST_ADD_OVF_EN defined: adds output ovf_sticky (1 bit, reset 0).
//   Set on any P update with r[48]=1.
//   Cleared on a P update whose Z select is not 2, which starts a new accumulation.
//   Set wins over clear in the same cycle.
//  DSP_POST_ADD_OVF_EN undefined: the port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package dsp48_post_pkg:
//   width constants (P_W=48, M_W=36);
//   opmode bit-index constants;
//   enums x_sel_t and z_sel_t;
//   function post_add(x, z, cin, sub) returning a 49-bit result.
//  Sub-module dsp_pipe_reg_n: param WIDTH and BYPASS, enable, async active-low reset.
//   Instantiated for the opmode, carry-in and P/CARRYOUT registers.
// TESTING
//  1 Reset: drive rst_n=0 mid-cycle with p=0x123 -> p, pcout, carryout read 0 immediately, before any clk edge.
//  2 Multiply-add: opmode=0x0D (X=m, Z=c), m=5, c=10, cin=0 -> p=15 one cycle later.
//    With opmode=0x8D -> p=5 (c - m).
//  3 Accumulate: opmode=0x09, m=3 for 4 cycles from p=0 -> p=3, 6, 9, 12.
//    Drop ce_p for 1 cycle -> p holds at 12.
//  4 Wrap: p=0xFFFF_FFFF_FFFF, X=m=1, Z=P -> p=0, carryout=1 for one cycle.
//    With the macro defined, ovf_sticky=1 and stays 1 until a Z!=2 update.
//  5 Carry-in: CARRYINSEL="CARRYIN", carryin=1, X=dab=0x7, Z=0 -> p=8.
//    Repeat with opmode[7]=1, Z=c=20 -> p=12.
//  6 PREG=0: p tracks c combinationally within the same cycle.
//    Select Z=2 -> p=0 and the assertion warning fires.

Source files
------------

// File: rtl/dsp48_post_pkg.sv
// Shared widths, opmode field positions, operand selects and the 49-bit post-adder
// function for the DSP48A1 post-adder/accumulator stage.
package dsp48_post_pkg;

  localparam int unsigned P_W   = 48;
  localparam int unsigned M_W   = 36;
  localparam int unsigned R_W   = P_W + 1;
  localparam int unsigned OPM_W = 8;

  localparam int unsigned OPM_X_LSB = 0;
  localparam int unsigned OPM_Z_LSB = 2;
  localparam int unsigned OPM_CIN   = 5;
  localparam int unsigned OPM_SUB   = 7;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_t;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_t;

  typedef struct packed {
    logic           carry;
    logic [P_W-1:0] sum;
  } post_res_t;

  // Add: z + x + cin. Subtract: z - (x + cin); bit 48 is then the borrow.
  function automatic logic [R_W-1:0] post_add(input logic [P_W-1:0] x,
                                               input logic [P_W-1:0] z,
                                               input logic           cin,
                                               input logic           sub);
    logic [R_W-1:0] xc;
    xc = {1'b0, x} + R_W'(cin);
    return sub ? ({1'b0, z} - xc) : ({1'b0, z} + xc);
  endfunction

endpackage

// File: rtl/dsp_pipe_reg_n.sv
// Optional pipeline register: enable-gated with async active-low clear, or a plain
// wire when BYPASS is set.
module dsp_pipe_reg_n #(
  parameter int unsigned WIDTH  = 1,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (BYPASS) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, en};
    assign q = d;
  end else begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (en) begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: X/Z operand muxing, add/subtract with carry-in, P register.
// Define DSP_POST_ADD_OVF_EN to add the ovf_sticky accumulation-overflow output.
module dsp_post_adder_acc
  import dsp48_post_pkg::*;
#(
  parameter bit    PREG       = 1'b1,
  parameter bit    OPMODEREG  = 1'b1,
  parameter bit    CARRYINREG = 1'b1,
  parameter string CARRYINSEL = "OPMODE5"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_opmode,
  input  logic             ce_carryin,
  input  logic             ce_p,
  input  logic [OPM_W-1:0] opmode,
  input  logic             carryin,
  input  logic [M_W-1:0]   m,
  input  logic [P_W-1:0]   dab,
  input  logic [P_W-1:0]   c,
  input  logic [P_W-1:0]   pcin,
  output logic [P_W-1:0]   p,
  output logic [P_W-1:0]   pcout,
  output logic             carryout,
`ifdef DSP_POST_ADD_OVF_EN
  output logic             ovf_sticky,
`endif
  output logic             carryoutf
);

  localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

  logic [OPM_W-1:0] opmode_q;
  logic             cin_sel;
  logic             cin_q;
  x_sel_t           x_sel;
  z_sel_t           z_sel;
  logic             sub;
  logic [P_W-1:0]   p_fb;
  logic [P_W-1:0]   x_op;
  logic [P_W-1:0]   z_op;
  post_res_t        res_d;
  post_res_t        res_q;
  logic             unused_bits;

  dsp_pipe_reg_n #(.WIDTH(OPM_W), .BYPASS(!OPMODEREG)) u_opmode_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ce_opmode),
    .d     (opmode),
    .q     (opmode_q)
  );

  // Carry-in is taken from the opmode port so that, when both are registered,
  // the carry lines up with the operand selects it belongs to.
  assign cin_sel = CIN_FROM_PORT ? carryin : opmode[OPM_CIN];

  dsp_pipe_reg_n #(.WIDTH(1), .BYPASS(!CARRYINREG)) u_cin_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ce_carryin),
    .d     (cin_sel),
    .q     (cin_q)
  );

  // Without a P register the feedback path would be a combinational loop, so it reads 0.
  if (PREG) begin : g_fb
    assign p_fb = res_q.sum;
  end else begin : g_no_fb
    assign p_fb = '0;
  end

  always_comb begin
    x_sel = x_sel_t'(opmode_q[OPM_X_LSB +: 2]);
    z_sel = z_sel_t'(opmode_q[OPM_Z_LSB +: 2]);
    sub   = opmode_q[OPM_SUB];
    x_op  = '0;
    z_op  = '0;
    case (x_sel)
      X_M:     x_op = P_W'(m);
      X_P:     x_op = p_fb;
      X_DAB:   x_op = dab;
      default: x_op = '0;
    endcase
    case (z_sel)
      Z_PCIN:  z_op = pcin;
      Z_P:     z_op = p_fb;
      Z_C:     z_op = c;
      default: z_op = '0;
    endcase
    res_d = post_res_t'(post_add(x_op, z_op, cin_q, sub));
  end

  dsp_pipe_reg_n #(.WIDTH($bits(post_res_t)), .BYPASS(!PREG)) u_p_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ce_p),
    .d     (res_d),
    .q     (res_q)
  );

  assign p         = res_q.sum;
  assign pcout     = res_q.sum;
  assign carryout  = res_q.carry;
  assign carryoutf = res_q.carry;

`ifdef DSP_POST_ADD_OVF_EN
  // A non-feedback Z select starts a fresh accumulation; a carry in the same update still sets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (ce_p) begin
      if (res_d.carry) begin
        ovf_sticky <= 1'b1;
      end else if (z_sel != Z_P) begin
        ovf_sticky <= 1'b0;
      end
    end
  end
`endif

  if (!PREG) begin : g_fb_check
    always @(posedge clk) begin
      if (rst_n) begin
        assert (x_sel != X_P && z_sel != Z_P)
          else $warning("post-adder P feedback selected with PREG=0; operand reads as zero");
      end
    end
  end

  assign unused_bits = ^{opmode_q[4], opmode_q[OPM_CIN], opmode_q[6], carryin};

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Scoreboard bench for dsp_post_adder_acc: default build (a), carry-in port select with
// unregistered controls (b), and a PREG=0 combinational build (c).
module tb_dsp_post_adder_acc;
  import dsp48_post_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ce_opmode = 1'b1;
  logic           ce_carryin = 1'b1;
  logic           ce_p = 1'b1;
  logic [7:0]     opmode_a = '0;
  logic [7:0]     opmode_b = '0;
  logic [7:0]     opmode_c = 8'h0C;
  logic           carryin = 1'b0;
  logic [35:0]    m = '0;
  logic [47:0]    dab = '0;
  logic [47:0]    c = '0;
  logic [47:0]    pcin = '0;

  logic [47:0]    p_a, pcout_a, p_b, pcout_b, p_c, pcout_c;
  logic           co_a, cof_a, co_b, cof_b, co_c, cof_c;
`ifdef DSP_POST_ADD_OVF_EN
  logic           ovf_a, ovf_b, ovf_c;
`endif

  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  typedef struct {
    string       tag;
    int unsigned dut;
    logic [47:0] p;
    logic        co;
    logic        ovf;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  dsp_post_adder_acc u_dut_a (
    .clk(clk), .rst_n(rst_n), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .opmode(opmode_a), .carryin(carryin), .m(m), .dab(dab), .c(c), .pcin(pcin),
    .p(p_a), .pcout(pcout_a), .carryout(co_a),
`ifdef DSP_POST_ADD_OVF_EN
    .ovf_sticky(ovf_a),
`endif
    .carryoutf(cof_a)
  );

  dsp_post_adder_acc #(.OPMODEREG(1'b0), .CARRYINREG(1'b0), .CARRYINSEL("CARRYIN")) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .opmode(opmode_b), .carryin(carryin), .m(m), .dab(dab), .c(c), .pcin(pcin),
    .p(p_b), .pcout(pcout_b), .carryout(co_b),
`ifdef DSP_POST_ADD_OVF_EN
    .ovf_sticky(ovf_b),
`endif
    .carryoutf(cof_b)
  );

  dsp_post_adder_acc #(.PREG(1'b0), .OPMODEREG(1'b0), .CARRYINREG(1'b0)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin), .ce_p(ce_p),
    .opmode(opmode_c), .carryin(carryin), .m(m), .dab(dab), .c(c), .pcin(pcin),
    .p(p_c), .pcout(pcout_c), .carryout(co_c),
`ifdef DSP_POST_ADD_OVF_EN
    .ovf_sticky(ovf_c),
`endif
    .carryoutf(cof_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected result, compare after the edge.
  task automatic step(input string tag, input int unsigned dut, input logic [7:0] opm,
                      input logic [35:0] mm, input logic [47:0] cc, input logic [47:0] dd,
                      input logic [47:0] pc, input logic cin, input logic cep,
                      input logic [47:0] ep, input logic eco, input logic eovf);
    exp_t e;
    @(negedge clk);
    if (dut == 0) opmode_a = opm;
    else          opmode_b = opm;
    m = mm; c = cc; dab = dd; pcin = pc; carryin = cin; ce_p = cep;
    e.tag = tag; e.dut = dut; e.p = ep; e.co = eco; e.ovf = eovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        check({e.tag, ".p"},     64'(p_a),     64'(e.p));
        check({e.tag, ".pcout"}, 64'(pcout_a), 64'(e.p));
        check({e.tag, ".co"},    64'(co_a),    64'(e.co));
        check({e.tag, ".cof"},   64'(cof_a),   64'(e.co));
`ifdef DSP_POST_ADD_OVF_EN
        check({e.tag, ".ovf"},   64'(ovf_a),   64'(e.ovf));
`endif
      end else begin
        check({e.tag, ".p"},     64'(p_b),     64'(e.p));
        check({e.tag, ".pcout"}, 64'(pcout_b), 64'(e.p));
        check({e.tag, ".co"},    64'(co_b),    64'(e.co));
        check({e.tag, ".cof"},   64'(cof_b),   64'(e.co));
`ifdef DSP_POST_ADD_OVF_EN
        check({e.tag, ".ovf"},   64'(ovf_b),   64'(e.ovf));
`endif
      end
    end
  endtask

  initial begin
    #1;
    check("rst.p_a",   64'(p_a),   64'h0);
    check("rst.pco_a", 64'(pcout_a), 64'h0);
    check("rst.co_a",  64'(co_a),  64'h0);
    check("rst.p_b",   64'(p_b),   64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // opmode takes effect one cycle after capture; ce_p=0 covers that setup cycle
    step("load_hold", 0, 8'h0C, 36'd0, 48'h123, 48'd0, 48'd0, 1'b0, 1'b0, 48'h0,   1'b0, 1'b0);
    step("load",      0, 8'h0C, 36'd0, 48'h123, 48'd0, 48'd0, 1'b0, 1'b1, 48'h123, 1'b0, 1'b0);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst.p",     64'(p_a),     64'h0);
    check("arst.pcout", 64'(pcout_a), 64'h0);
    check("arst.co",    64'(co_a),    64'h0);
    check("arst.cof",   64'(cof_a),   64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    step("madd_setup", 0, 8'h0D, 36'd5, 48'd10, 48'd0, 48'd0, 1'b0, 1'b0, 48'd0,  1'b0, 1'b0);
    step("madd",       0, 8'h0D, 36'd5, 48'd10, 48'd0, 48'd0, 1'b0, 1'b1, 48'd15, 1'b0, 1'b0);
    step("sub_lat",    0, 8'h8D, 36'd5, 48'd10, 48'd0, 48'd0, 1'b0, 1'b1, 48'd15, 1'b0, 1'b0);
    step("msub",       0, 8'h8D, 36'd5, 48'd10, 48'd0, 48'd0, 1'b0, 1'b1, 48'd5,  1'b0, 1'b0);

    step("acc_clr",    0, 8'h09, 36'd0, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 48'd0,  1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("acc%0d", i), 0, 8'h09, 36'd3, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1,
           48'(3 * i), 1'b0, 1'b0);
    end
    step("acc_hold",   0, 8'h09, 36'd3, 48'd0, 48'd0, 48'd0, 1'b0, 1'b0, 48'd12, 1'b0, 1'b0);
    step("acc_resume", 0, 8'h09, 36'd3, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 48'd15, 1'b0, 1'b0);

    step("wrap_setup", 0, 8'h0C, 36'd3, ONES,  48'd0, 48'd0, 1'b0, 1'b0, 48'd15, 1'b0, 1'b0);
    step("wrap_load",  0, 8'h09, 36'd1, ONES,  48'd0, 48'd0, 1'b0, 1'b1, ONES,   1'b0, 1'b0);
    step("wrap",       0, 8'h09, 36'd1, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 48'd0,  1'b1, 1'b1);
    step("wrap_after", 0, 8'h09, 36'd1, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 48'd1,  1'b0, 1'b1);
    step("ovf_keep",   0, 8'h0C, 36'd1, 48'd7, 48'd0, 48'd0, 1'b0, 1'b1, 48'd2,  1'b0, 1'b1);
    step("ovf_clr",    0, 8'h0C, 36'd1, 48'd7, 48'd0, 48'd0, 1'b0, 1'b1, 48'd7,  1'b0, 1'b0);

    step("brw_setup",  0, 8'h8D, 36'd1, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 48'd0,  1'b0, 1'b0);
    step("borrow",     0, 8'h8D, 36'd1, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, ONES,   1'b1, 1'b1);

    step("cin_setup",  0, 8'h2D, 36'd5, 48'd10, 48'd0, 48'd0, 1'b0, 1'b1, 48'd5,  1'b0, 1'b0);
    step("cin_op5",    0, 8'h2D, 36'd5, 48'd10, 48'd0, 48'd0, 1'b0, 1'b1, 48'd16, 1'b0, 1'b0);
    ce_opmode = 1'b0;
    ce_carryin = 1'b0;
    step("ce_opm_off", 0, 8'h0C, 36'd5, 48'd10, 48'd0, 48'd0, 1'b0, 1'b1, 48'd16, 1'b0, 1'b0);
    ce_opmode = 1'b1;
    ce_carryin = 1'b1;
    step("ce_opm_on",  0, 8'h07, 36'd5, 48'd10, 48'h100, 48'h20, 1'b0, 1'b1, 48'd16, 1'b0, 1'b0);
    step("dab_pcin",   0, 8'h07, 36'd5, 48'd10, 48'h100, 48'h20, 1'b0, 1'b1, 48'h120, 1'b0, 1'b0);

    step("b_cin",      1, 8'h03, 36'd0, 48'd0,  48'd7, 48'd0,  1'b1, 1'b1, 48'd8,    1'b0, 1'b0);
    step("b_cin_sub",  1, 8'h8F, 36'd0, 48'd20, 48'd7, 48'd0,  1'b1, 1'b1, 48'd12,   1'b0, 1'b0);
    step("b_op5_ign",  1, 8'h23, 36'd0, 48'd0,  48'd7, 48'd0,  1'b0, 1'b1, 48'd7,    1'b0, 1'b0);
    step("b_pcin",     1, 8'h07, 36'd0, 48'd0,  48'd5, 48'h30, 1'b0, 1'b1, 48'h35,   1'b0, 1'b0);

    @(negedge clk);
    carryin = 1'b0; ce_p = 1'b1; m = 36'd1;
    opmode_c = 8'h0C; c = 48'h55;
    #1;
    check("c_comb0.p",     64'(p_c),     64'h55);
    check("c_comb0.pcout", 64'(pcout_c), 64'h55);
    c = 48'h66;
    #1;
    check("c_comb1.p",     64'(p_c),     64'h66);
    opmode_c = 8'h8D; c = 48'd0;
    #1;
    check("c_borrow.p",    64'(p_c),     64'(ONES));
    check("c_borrow.co",   64'(co_c),    64'h1);
    check("c_borrow.cof",  64'(cof_c),   64'h1);
    @(posedge clk);
    #1;
`ifdef DSP_POST_ADD_OVF_EN
    check("c_ovf_set", 64'(ovf_c), 64'h1);
`endif
    @(negedge clk);
    opmode_c = 8'h08; c = 48'h77;
    #1;
    check("c_zfb.p",  64'(p_c),  64'h0);
    check("c_zfb.co", 64'(co_c), 64'h0);
    @(posedge clk);
    #1;
`ifdef DSP_POST_ADD_OVF_EN
    check("c_ovf_keep", 64'(ovf_c), 64'h1);
`endif
    @(negedge clk);
    opmode_c = 8'h09; m = 36'd3;
    #1;
    check("c_acc_fb0.p", 64'(p_c), 64'h3);
    opmode_c = 8'h0C; c = 48'h99;
    #1;
    check("c_zc.p", 64'(p_c), 64'h99);
    @(posedge clk);
    #1;
`ifdef DSP_POST_ADD_OVF_EN
    check("c_ovf_clr", 64'(ovf_c), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
